// File: rtl/dunit_imem_loader_if.sv
// Byte-stream-in / instruction-memory-write-out bundle for dunit_imem_loader.
// master = debug host side (start + UART bytes), slave = the loader itself.
interface dunit_imem_loader_if #(
    parameter int NB_REG   = 32,
    parameter int NB_WIDHT = 9
);
    logic                  i_start;
    logic [7:0]            i_rx_data;
    logic                  i_rx_valid;
    logic                  o_dunit_w_en;
    logic [NB_WIDHT-1:0]   o_dunit_addr;
    logic [NB_REG-1:0]     o_dunit_data;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_error;
    logic [NB_WIDHT-2:0]   o_word_count;

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_dunit_w_en, o_dunit_addr, o_dunit_data,
        input  o_busy, o_done, o_error, o_word_count
    );

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_dunit_w_en, o_dunit_addr, o_dunit_data,
        output o_busy, o_done, o_error, o_word_count
    );
endinterface

// File: rtl/dunit_imem_loader.sv
// Packs UART bytes big-endian into 32-bit words and writes them to instruction memory.
// Optional IMEM_LOADER_CHECKSUM_EN: trailing XOR checksum byte verified after HALT.
module dunit_imem_loader #(
    parameter int                NB_REG    = 32,
    parameter int                NB_WIDHT  = 9,
    parameter logic [NB_REG-1:0] HALT_INST = 32'hFFFFFFFF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    dunit_imem_loader_if.slave    bus
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERROR, CHECK} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERROR} state_t;
`endif

    localparam logic [NB_WIDHT-1:0] LAST_ADDR = {{(NB_WIDHT-2){1'b1}}, 2'b00};

    state_t                state_q;
    logic [NB_REG-1:0]     word_q;
    logic [1:0]            byte_cnt_q;
    logic [NB_WIDHT-1:0]   ptr_q;
    logic                  w_en_q;
    logic [NB_WIDHT-1:0]   addr_q;
    logic [NB_REG-1:0]     data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic [NB_WIDHT-2:0]   word_count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            xor_q;
`endif

    logic [NB_REG-1:0]     word_d;
    logic [NB_WIDHT-1:0]   ptr_d;
    logic                  last_slot;
    logic                  is_halt;

    always_comb begin
        word_d    = {word_q[NB_REG-9:0], bus.i_rx_data};
        last_slot = (ptr_q == LAST_ADDR);
        // Pointer saturates at the last slot so it never wraps back to 0.
        ptr_d     = last_slot ? ptr_q : ptr_q + NB_WIDHT'(4);
        is_halt   = (data_q == HALT_INST);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            word_q       <= '0;
            byte_cnt_q   <= '0;
            ptr_q        <= '0;
            w_en_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (bus.i_start) begin
                        state_q      <= LOAD;
                        ptr_q        <= '0;
                        byte_cnt_q   <= '0;
                        word_count_q <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q        <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (bus.i_rx_valid) begin
                        word_q <= word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q  <= xor_q ^ bus.i_rx_data;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            byte_cnt_q <= '0;
                            state_q    <= WRITE;
                            w_en_q     <= 1'b1;
                            addr_q     <= ptr_q;
                            data_q     <= word_d;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    w_en_q       <= 1'b0;
                    word_count_q <= word_count_q + (NB_WIDHT-1)'(1);
                    ptr_q        <= ptr_d;
                    if (is_halt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        // A byte arriving in the HALT write cycle is already the checksum.
                        if (bus.i_rx_valid) begin
                            state_q <= (bus.i_rx_data == xor_q) ? DONE : ERROR;
                            done_q  <= (bus.i_rx_data == xor_q);
                            error_q <= (bus.i_rx_data != xor_q);
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= CHECK;
                        end
`else
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
`endif
                    end else if (last_slot) begin
                        state_q <= ERROR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= LOAD;
                        if (bus.i_rx_valid) begin
                            word_q     <= word_d;
                            byte_cnt_q <= 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            xor_q      <= xor_q ^ bus.i_rx_data;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (bus.i_rx_valid) begin
                        state_q <= (bus.i_rx_data == xor_q) ? DONE : ERROR;
                        done_q  <= (bus.i_rx_data == xor_q);
                        error_q <= (bus.i_rx_data != xor_q);
                        busy_q  <= 1'b0;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_dunit_w_en = w_en_q;
    assign bus.o_dunit_addr = addr_q;
    assign bus.o_dunit_data = data_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_error      = error_q;
    assign bus.o_word_count = word_count_q;

endmodule

// File: tb/tb_dunit_imem_loader.sv
// Randomized bench for dunit_imem_loader against a byte-stream reference model.
// Define IMEM_LOADER_CHECKSUM_EN to also exercise the checksum build.
module tb_dunit_imem_loader;
    localparam int          NB_REG    = 32;
    localparam int          NB_WIDHT  = 9;
    localparam logic [31:0] HALT      = 32'hFFFFFFFF;
    localparam int unsigned MAX_WORDS = 2 ** (NB_WIDHT - 2);

    logic i_clk = 1'b0;
    logic i_reset;

    dunit_imem_loader_if #(.NB_REG(NB_REG), .NB_WIDHT(NB_WIDHT)) bus ();

    dunit_imem_loader #(
        .NB_REG(NB_REG),
        .NB_WIDHT(NB_WIDHT),
        .HALT_INST(HALT)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .bus(bus.slave)
    );

    always #5 i_clk = ~i_clk;

    int unsigned cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
        int unsigned cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];

    always @(negedge i_clk) begin
        if (bus.o_dunit_w_en === 1'b1)
            obs_q.push_back('{int'(bus.o_dunit_addr), bus.o_dunit_data, cyc});
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a load is a stream of bytes, grouped by four into words
    // written at 4*index; it ends at HALT (or checksum) or after MAX_WORDS words.
    bit          m_active;
    bit          m_await_ck;
    bit          m_done;
    bit          m_err;
    logic [7:0]  m_bytes[$];
    logic [7:0]  m_xor;
    int unsigned m_words;

    task automatic model_reset();
        m_active = 0; m_await_ck = 0; m_done = 0; m_err = 0;
        m_bytes.delete(); m_xor = '0; m_words = 0;
    endtask

    task automatic model_start();
        model_reset();
        m_active = 1;
    endtask

    task automatic model_byte(input logic [7:0] b, input int unsigned drive_cyc);
        logic [31:0] w;
        if (m_await_ck) begin
            m_await_ck = 0;
            m_done = (b == m_xor);
            m_err  = (b != m_xor);
            return;
        end
        if (!m_active) return;
        m_xor = m_xor ^ b;
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
            w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
            m_bytes.delete();
            exp_q.push_back('{m_words * 4, w, drive_cyc + 1});
            m_words++;
            if (w == HALT) begin
                m_active = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                m_await_ck = 1;
`else
                m_done = 1;
`endif
            end else if (m_words == MAX_WORDS) begin
                m_active = 0;
                m_err = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        model_byte(b, cyc);
        tick();
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = $urandom;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input bit random_gap);
        for (int i = 0; i < 4; i++)
            send_byte(w[31-8*i -: 8], random_gap ? $urandom_range(0, 2) : 0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h0;
        return w;
    endfunction

    task automatic start_load();
        bus.i_start = 1'b1;
        model_start();
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        int unsigned n;
        repeat (3) tick();
        check({tag, "_nwr"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), obs_q[i].addr, exp_q[i].addr);
            check($sformatf("%s_data%0d", tag, i), obs_q[i].data, exp_q[i].data);
            check($sformatf("%s_cyc%0d", tag, i), obs_q[i].cyc, exp_q[i].cyc);
        end
    endtask

    task automatic clear_writes();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_busy"}, bus.o_busy, m_active || m_await_ck);
        check({tag, "_done"}, bus.o_done, m_done);
        check({tag, "_err"}, bus.o_error, m_err);
        check({tag, "_wcnt"}, bus.o_word_count, m_words);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wen"}, bus.o_dunit_w_en, 1'b0);
        check({tag, "_addr"}, bus.o_dunit_addr, '0);
        check({tag, "_data"}, bus.o_dunit_data, '0);
        check({tag, "_busy"}, bus.o_busy, 1'b0);
        check({tag, "_done"}, bus.o_done, 1'b0);
        check({tag, "_err"}, bus.o_error, 1'b0);
        check({tag, "_wcnt"}, bus.o_word_count, '0);
    endtask

    task automatic send_checksum(input bit good);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(good ? m_xor : ~m_xor, 0);
`else
        if (good) return;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nw;
        bus.i_start    = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = '0;
        i_reset        = 1'b1;
        model_reset();
        repeat (3) tick();
        check_all_zero("reset");
        i_reset = 1'b0;
        tick();

        // Bytes with no start are ignored
        for (int i = 0; i < 4; i++) send_byte(8'hAA + 8'(i * 17), 0);
        compare_writes("idle");
        check("idle_busy", bus.o_busy, 1'b0);
        clear_writes();

        // Directed two-word program ending in HALT
        start_load();
        send_word(32'h20080005, 1);
        send_word(HALT, 1);
        send_checksum(1);
        compare_writes("basic");
        check_status("basic");
        check("basic_done_lit", bus.o_done, 1'b1);
        check("basic_wcnt_lit", bus.o_word_count, 2);
        clear_writes();

        // Back-to-back strobes through the WRITE cycle
        start_load();
        send_word(32'h11223344, 0);
        send_word(32'h55667788, 0);
        send_word(HALT, 0);
        send_checksum(1);
        compare_writes("b2b");
        if (obs_q.size() >= 2) begin
            check("b2b_w0_lit", obs_q[0].data, 32'h11223344);
            check("b2b_w1_lit", obs_q[1].data, 32'h55667788);
        end
        check_status("b2b");
        clear_writes();

        // Randomized programs with random gaps and stray trailing bytes
        for (int t = 0; t < 6; t++) begin
            start_load();
            nw = $urandom_range(1, 10);
            for (int unsigned k = 0; k < nw; k++) send_word(rand_word(), 1);
            send_word(HALT, 1);
            send_checksum(($urandom_range(0, 3) != 0));
            for (int k = 0; k < 3; k++) send_byte($urandom, $urandom_range(0, 1));
            compare_writes($sformatf("rnd%0d", t));
            check_status($sformatf("rnd%0d", t));
            clear_writes();
        end

        // Fill every slot without HALT
        start_load();
        for (int unsigned k = 0; k < MAX_WORDS; k++) send_word(rand_word(), 1);
        send_word(rand_word(), 0);
        compare_writes("fill");
        if (obs_q.size() > 0)
            check("fill_last_addr", obs_q[obs_q.size()-1].addr, 9'h1FC);
        check("fill_err_lit", bus.o_error, 1'b1);
        check("fill_wcnt_lit", bus.o_word_count, MAX_WORDS);
        check_status("fill");
        clear_writes();

        // Reset in the middle of word 3
        start_load();
        for (int k = 0; k < 3; k++) send_word(rand_word(), 1);
        compare_writes("pre_rst");
        clear_writes();
        send_byte($urandom, 0);
        send_byte($urandom, 0);
        i_reset = 1'b1;
        model_reset();
        tick();
        check_all_zero("midrst");
        i_reset = 1'b0;
        tick();
        start_load();
        send_word(rand_word(), 0);
        compare_writes("post_rst");
        check_status("post_rst");
        clear_writes();

`ifdef IMEM_LOADER_CHECKSUM_EN
        start_load();
        send_word(32'h01020304, 1);
        send_word(HALT, 1);
        send_byte(8'h04, 0);
        compare_writes("ck_good");
        check("ck_good_done", bus.o_done, 1'b1);
        check("ck_good_err", bus.o_error, 1'b0);
        clear_writes();

        start_load();
        send_word(32'h01020304, 1);
        send_word(HALT, 1);
        send_byte(8'h05, 0);
        compare_writes("ck_bad");
        check("ck_bad_done", bus.o_done, 1'b0);
        check("ck_bad_err", bus.o_error, 1'b1);
        clear_writes();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dunit_imem_loader.md
Name: dunit_imem_loader

Overview:
- Debug-unit-side writer for the IF stage instruction memory port; drives `i_dunit_w_en`, `i_dunit_addr` and `i_dunit_data`.
- Receives a byte stream from the UART receiver and packs 4 bytes big-endian into one 32-bit instruction.
- Writes each packed word to consecutive word-aligned byte addresses starting at 0.
- Stops after writing the HALT instruction or when memory is full.

Parameters:
- NB_REG, 32, instruction/data width (fixed at 32).
- NB_WIDHT, 9, instruction memory byte-address width.
- HALT_INST, 32'hFFFFFFFF, terminating instruction; it is written to memory, then the load ends.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; begins a load. Sampled only in IDLE, DONE and ERROR.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid in that cycle.
- o_dunit_w_en  out  1  instruction memory write enable; one-cycle pulse per word.
- o_dunit_addr  out  NB_WIDHT  byte address of the word being written.
- o_dunit_data  out  NB_REG  word being written.
- o_busy  out  1  high in LOAD and WRITE.
- o_done  out  1  level; high in DONE.
- o_error  out  1  level; high in ERROR.
- o_word_count  out  NB_WIDHT-1  number of words written in the current or last load.

Behaviour:
- Reset (synchronous, i_reset=1 at a rising edge):
  - State goes to IDLE.
  - All outputs 0; byte counter 0; address pointer 0.
  - Reset mid-load aborts immediately; no further write pulse is issued.
- States: IDLE, LOAD, WRITE, DONE, ERROR.
- IDLE:
  - Bytes are ignored.
  - i_start clears the pointer, byte counter and o_word_count, then moves to LOAD.
- LOAD:
  - Each i_rx_valid shifts the byte in: word <= {word[23:0], i_rx_data}, so the first byte lands in [31:24].
  - The 4th byte moves the state to WRITE on the same edge.
- WRITE (exactly one cycle):
  - o_dunit_w_en=1, o_dunit_addr=pointer, o_dunit_data=assembled word. Write latency is 1 cycle after the edge that accepted the 4th byte.
  - On exit: pointer += 4, o_word_count += 1.
  - A byte strobed during WRITE is accepted as byte 0 of the next word; no byte is ever dropped.
  - Next state:
    - Word == HALT_INST -> DONE.
    - Else pointer == 2^NB_WIDHT-4 (last slot just written) -> ERROR.
    - Else -> LOAD.
- DONE / ERROR:
  - Hold outputs; o_done or o_error high.
  - Bytes are ignored.
  - i_start begins a new load; o_done and o_error clear on that edge.
- Other signals:
  - i_start in LOAD or WRITE is ignored.
  - o_dunit_addr and o_dunit_data are don't-care when o_dunit_w_en=0; both hold their last values.
  - The pointer never wraps. In ERROR, o_word_count = 2^(NB_WIDHT-2).
- A partial word (1-3 bytes) stays pending indefinitely. There is no timeout; only reset or a new i_start after DONE/ERROR discards it.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of every accepted data byte is kept.
  - After the HALT word write, the state goes to CHECK instead of DONE.
  - The next received byte is compared with the XOR: equal -> DONE; mismatch -> ERROR.
  - The XOR clears on i_start and on reset.
- Undefined: no CHECK state; HALT goes directly to DONE and no checksum logic exists.

Test Plan:
- Reset then i_start; bytes 20,08,00,05 then FF,FF,FF,FF -> w_en pulses at addr 0 data 32'h20080005 and at addr 4 data 32'hFFFFFFFF; o_done=1; o_word_count=2.
- Bytes in IDLE (no i_start): send AA,BB,CC,DD -> no w_en pulse; o_busy=0.
- Back-to-back strobes: 4th byte of word 0, then a byte in the WRITE cycle -> w_en 1 cycle after the 4th byte, and the next word includes that byte (data 32'h11223344, then 32'h55...).
- Fill: 128 non-HALT words with NB_WIDHT=9 -> last write at addr 9'h1FC; o_error=1; o_word_count=128; no 129th pulse.
- Reset asserted after 2 bytes of word 3 -> all outputs 0 next cycle; a subsequent i_start plus a full word writes at addr 0.
- With IMEM_LOADER_CHECKSUM_EN: word 01020304 + HALT + checksum 04 -> o_done=1; the same stream with checksum 05 -> o_error=1.
